// File: rtl/uop_pkg.sv
// rtl/uop_pkg.sv - opcodes, flag bit indices, decode entry type and reset defaults
package uop_pkg;

  localparam int ALU_BITS  = 8;
  localparam int CTRL_BITS = 8;
  localparam int STEP_BITS = 2;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_XOR = 2;
  localparam int OP_NOR = 3;
  localparam int OP_AND = 4;
  localparam int OP_SRL = 5;
  localparam int OP_SRA = 6;
  localparam int OP_JLR = 7;
  localparam int OP_JLI = 8;
  localparam int OP_ADI = 12;
  localparam int OP_STB = 13;
  localparam int OP_LDB = 14;
  localparam int OP_LDI = 15;

  localparam int ALU_CI = 7;
  localparam int ALU_NB = 6;
  localparam int ALU_IC = 5;
  localparam int ALU_NA = 4;
  localparam int ALU_XO = 3;
  localparam int ALU_NO = 2;
  localparam int ALU_SR = 1;
  localparam int ALU_SS = 0;

  localparam int CTRL_IMM = 6;
  localparam int CTRL_WPC = 5;
  localparam int CTRL_SPC = 4;
  localparam int CTRL_LNK = 3;
  localparam int CTRL_MW  = 2;
  localparam int CTRL_MR  = 1;
  localparam int CTRL_LD  = 0;

  typedef struct packed {
    logic                 valid;
    logic [ALU_BITS-1:0]  alu;
    logic [CTRL_BITS-1:0] ctrl;
    logic [STEP_BITS-1:0] steps;
  } uop_entry_t;

  function automatic uop_entry_t default_entry(input int opcode);
    uop_entry_t e;
    e       = '0;
    e.valid = 1'b1;
    case (opcode)
      OP_ADD: e.alu = 8'b0000_0000;
      OP_SUB: e.alu = 8'b1100_0000;
      OP_XOR: e.alu = 8'b0010_0000;
      OP_NOR: e.alu = 8'b0010_1100;
      OP_AND: e.alu = 8'b0111_1100;
      OP_SRL: e.alu = 8'b0000_0010;
      OP_SRA: e.alu = 8'b0000_0011;
      OP_JLR: begin e.ctrl = 8'b0001_1000; e.steps = 2'd1; end
      OP_JLI: begin e.ctrl = 8'b0010_1000; e.steps = 2'd1; end
      OP_ADI: e.ctrl = 8'b0100_0000;
      OP_STB: begin e.ctrl = 8'b0000_0100; e.steps = 2'd1; end
      OP_LDB: begin e.ctrl = 8'b0000_0010; e.steps = 2'd1; end
      OP_LDI: e.ctrl = 8'b0000_0001;
      default: e.valid = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/uop_table.sv
// rtl/uop_table.sv - writable decode table with reset-loaded defaults and async read port
module uop_table
  import uop_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int ALU_W  = 8,
  parameter int CTRL_W = 8,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [OPC_W-1:0]  cfg_addr,
  input  logic [ALU_W-1:0]  cfg_alu,
  input  logic [CTRL_W-1:0] cfg_ctrl,
  input  logic [STEP_W-1:0] cfg_steps,
  input  logic [OPC_W-1:0]  rd_addr,
  output logic              rd_valid,
  output logic [ALU_W-1:0]  rd_alu,
  output logic [CTRL_W-1:0] rd_ctrl,
  output logic [STEP_W-1:0] rd_steps
);

  localparam int DEPTH = 2 ** OPC_W;

  logic [DEPTH-1:0] valid_v;
  logic [ALU_W-1:0]  alu_v   [DEPTH];
  logic [CTRL_W-1:0] ctrl_v  [DEPTH];
  logic [STEP_W-1:0] steps_v [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    localparam uop_entry_t DEF = default_entry(g);

    logic              v_q;
    logic [ALU_W-1:0]  a_q;
    logic [CTRL_W-1:0] c_q;
    logic [STEP_W-1:0] s_q;

    // Reset restores the default image, so run-time programming never survives rst.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= DEF.valid;
        a_q <= ALU_W'(DEF.alu);
        c_q <= CTRL_W'(DEF.ctrl);
        s_q <= STEP_W'(DEF.steps);
      end else if (cfg_we && (cfg_addr == OPC_W'(g))) begin
        v_q <= 1'b1;
        a_q <= cfg_alu;
        c_q <= cfg_ctrl;
        s_q <= cfg_steps;
      end
    end

    assign valid_v[g] = v_q;
    assign alu_v[g]   = a_q;
    assign ctrl_v[g]  = c_q;
    assign steps_v[g] = s_q;
  end

  // Read sees pre-write contents, so a same-cycle accept uses the old entry.
  assign rd_valid = valid_v[rd_addr];
  assign rd_alu   = alu_v[rd_addr];
  assign rd_ctrl  = ctrl_v[rd_addr];
  assign rd_steps = steps_v[rd_addr];

endmodule

// File: rtl/uop_sequencer.sv
// rtl/uop_sequencer.sv - opcode decode and multi-beat micro-op issue with back-pressure
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int ALU_W  = 8,
  parameter int CTRL_W = 8,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALU_W-1:0]  out_alu_flags,
  output logic [CTRL_W-1:0] out_ctrl_flags,
  output logic [STEP_W-1:0] out_step,
  output logic              out_last,
  output logic              out_illegal,
  input  logic              cfg_we,
  input  logic [OPC_W-1:0]  cfg_addr,
  input  logic [ALU_W-1:0]  cfg_alu,
  input  logic [CTRL_W-1:0] cfg_ctrl,
  input  logic [STEP_W-1:0] cfg_steps
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t            state_q, state_d;
  logic [ALU_W-1:0]  alu_q, alu_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              illegal_q, illegal_d;

  logic              rd_valid;
  logic [ALU_W-1:0]  rd_alu;
  logic [CTRL_W-1:0] rd_ctrl;
  logic [STEP_W-1:0] rd_steps;
  logic              accept;

  uop_table #(
    .OPC_W  (OPC_W),
    .ALU_W  (ALU_W),
    .CTRL_W (CTRL_W),
    .STEP_W (STEP_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_alu   (cfg_alu),
    .cfg_ctrl  (cfg_ctrl),
    .cfg_steps (cfg_steps),
    .rd_addr   (in_opcode),
    .rd_valid  (rd_valid),
    .rd_alu    (rd_alu),
    .rd_ctrl   (rd_ctrl),
    .rd_steps  (rd_steps)
  );

  assign out_valid      = (state_q == S_ISSUE);
  assign out_last       = out_valid && (step_q == steps_q);
  assign out_alu_flags  = alu_q;
  assign out_ctrl_flags = ctrl_q;
  assign out_step       = step_q;
  assign out_illegal    = illegal_q;
  assign in_ready       = !out_valid || (out_ready && out_last);
  assign accept         = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    alu_d     = alu_q;
    ctrl_d    = ctrl_q;
    steps_d   = steps_q;
    step_d    = step_q;
    illegal_d = illegal_q;
    if (accept) begin
      state_d = S_ISSUE;
      step_d  = '0;
      // An empty entry issues a single flagless beat marked illegal.
      if (rd_valid) begin
        alu_d     = rd_alu;
        ctrl_d    = rd_ctrl;
        steps_d   = rd_steps;
        illegal_d = 1'b0;
      end else begin
        alu_d     = '0;
        ctrl_d    = '0;
        steps_d   = '0;
        illegal_d = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state_d = S_IDLE;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      alu_q     <= '0;
      ctrl_q    <= '0;
      steps_q   <= '0;
      step_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_q     <= alu_d;
      ctrl_q    <= ctrl_d;
      steps_q   <= steps_d;
      step_q    <= step_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// tb/tb_uop_sequencer.sv - directed checks of decode, multi-beat issue, back-pressure, cfg and reset
module tb_uop_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_alu_flags;
  logic [7:0] out_ctrl_flags;
  logic [1:0] out_step;
  logic       out_last;
  logic       out_illegal;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_alu;
  logic [7:0] cfg_ctrl;
  logic [1:0] cfg_steps;

  int tests_run = 0;
  int tests_failed = 0;

  uop_sequencer #(
    .OPC_W  (4),
    .ALU_W  (8),
    .CTRL_W (8),
    .STEP_W (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_opcode      (in_opcode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_flags  (out_alu_flags),
    .out_ctrl_flags (out_ctrl_flags),
    .out_step       (out_step),
    .out_last       (out_last),
    .out_illegal    (out_illegal),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_alu        (cfg_alu),
    .cfg_ctrl       (cfg_ctrl),
    .cfg_steps      (cfg_steps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] alu, input logic [7:0] ctrl,
                            input logic [1:0] step, input logic last, input logic illegal);
    check({tag, " valid"},   32'(out_valid), 32'd1);
    check({tag, " alu"},     32'(out_alu_flags), 32'(alu));
    check({tag, " ctrl"},    32'(out_ctrl_flags), 32'(ctrl));
    check({tag, " step"},    32'(out_step), 32'(step));
    check({tag, " last"},    32'(out_last), 32'(last));
    check({tag, " illegal"}, 32'(out_illegal), 32'(illegal));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " valid"},   32'(out_valid), 32'd0);
    check({tag, " alu"},     32'(out_alu_flags), 32'd0);
    check({tag, " ctrl"},    32'(out_ctrl_flags), 32'd0);
    check({tag, " step"},    32'(out_step), 32'd0);
    check({tag, " last"},    32'(out_last), 32'd0);
    check({tag, " illegal"}, 32'(out_illegal), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [3:0] b2b_ops [3];
  logic [7:0] b2b_alu [3];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_alu = '0; cfg_ctrl = '0; cfg_steps = '0;
    b2b_ops[0] = 4'h0; b2b_ops[1] = 4'h2; b2b_ops[2] = 4'h4;
    b2b_alu[0] = 8'h00; b2b_alu[1] = 8'h20; b2b_alu[2] = 8'h7C;

    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    // single sub
    out_ready = 1'b1; in_valid = 1'b1; in_opcode = 4'h1;
    tick();
    in_valid = 1'b0;
    check_beat("sub", 8'hC0, 8'h00, 2'd0, 1'b1, 1'b0);
    tick();
    check("sub done", 32'(out_valid), 32'd0);

    // back-to-back add, xor, and
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_opcode = b2b_ops[i];
      check($sformatf("b2b%0d in_ready", i), 32'(in_ready), 32'd1);
      tick();
      check_beat($sformatf("b2b%0d", i), b2b_alu[i], 8'h00, 2'd0, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    tick();
    check("b2b done", 32'(out_valid), 32'd0);

    // ldb under back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_opcode = 4'hE;
    check("ldb in_ready idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_beat("ldb s0", 8'h00, 8'h02, 2'd0, 1'b0, 1'b0);
    check("ldb s0 in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_beat($sformatf("ldb hold%0d", i), 8'h00, 8'h02, 2'd0, 1'b0, 1'b0);
      check($sformatf("ldb hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("ldb s0 ready in_ready", 32'(in_ready), 32'd0);
    tick();
    check_beat("ldb s1", 8'h00, 8'h02, 2'd1, 1'b1, 1'b0);
    check("ldb s1 in_ready", 32'(in_ready), 32'd1);
    tick();
    check("ldb done", 32'(out_valid), 32'd0);

    // unprogrammed opcode 9
    in_valid = 1'b1; in_opcode = 4'h9;
    tick();
    in_valid = 1'b0;
    check_beat("ill9", 8'h00, 8'h00, 2'd0, 1'b1, 1'b1);
    tick();
    check("ill9 done", 32'(out_valid), 32'd0);

    // program 9 in the same cycle it is accepted
    cfg_we = 1'b1; cfg_addr = 4'h9; cfg_alu = 8'hAA; cfg_ctrl = 8'h00; cfg_steps = 2'd2;
    in_valid = 1'b1; in_opcode = 4'h9;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    check_beat("cfg same", 8'h00, 8'h00, 2'd0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b1; in_opcode = 4'h9;
    tick();
    in_valid = 1'b0;
    check_beat("cfg9 s0", 8'hAA, 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    check_beat("cfg9 s1", 8'hAA, 8'h00, 2'd1, 1'b0, 1'b0);
    tick();
    check_beat("cfg9 s2", 8'hAA, 8'h00, 2'd2, 1'b1, 1'b0);
    tick();
    check("cfg9 done", 32'(out_valid), 32'd0);

    // reset during jli restores defaults
    in_valid = 1'b1; in_opcode = 4'h8;
    tick();
    in_valid = 1'b0;
    check_beat("jli s0", 8'h00, 8'h28, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("mid rst");
    in_valid = 1'b1; in_opcode = 4'h9;
    tick();
    in_valid = 1'b0;
    check_beat("post rst 9", 8'h00, 8'h00, 2'd0, 1'b1, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
